// File: rtl/axi4_lite_mem_ws_pkg.sv
// Shared response codes and FSM state types for the
// wait-state AXI4-Lite scratch memory.
package axi4_lite_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_t;

    function automatic logic [1:0] resp_of(input logic oor);
        return oor ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_mem_ws_if.sv
// AXI4-Lite bus bundle shared by the memory and its masters.
interface axi4_lite_mem_ws_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_mem_ws_ram.sv
// Byte-enabled single-clock RAM, one write port and one
// registered read port; contents are never reset.
module axi4_lite_mem_ws_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic                  re,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read-before-write: a same-edge collision returns old data.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[ridx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi4_lite_mem_ws.sv
// AXI4-Lite slave memory with byte strobes, out-of-order
// AW/W capture, programmable read wait states and SLVERR.
module axi4_lite_mem_ws
    import axi4_lite_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int READ_WAIT  = 0
) (
    input logic               clk,
    input logic               rst,
    axi4_lite_mem_ws_if.slave bus
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int TOP_SH   = ADDR_LSB + IDX_W;
    localparam logic [3:0] RW_CNT = 4'(READ_WAIT);

    // ---------------- write channel ----------------
    w_state_t w_state_q, w_state_d;
    logic aw_held_q, aw_held_d;
    logic w_held_q, w_held_d;
    logic awready_q, awready_d;
    logic wready_q, wready_d;
    logic bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic wr_oor;

    assign aw_hs   = bus.awvalid & awready_q;
    assign w_hs    = bus.wvalid & wready_q;
    assign wr_addr = aw_held_q ? awaddr_q : bus.awaddr;
    assign wr_data = w_held_q ? wdata_q : bus.wdata;
    assign wr_strb = w_held_q ? wstrb_q : bus.wstrb;
    assign wr_oor  = (wr_addr >> TOP_SH) != '0;
    // Commit on the edge where the second half arrives.
    assign commit  = (w_state_q == W_IDLE)
                   & (aw_held_q | aw_hs)
                   & (w_held_q | w_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = bus.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = bus.wdata;
                    wstrb_d  = bus.wstrb;
                end
                if (commit) begin
                    w_state_d = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Readies come back one cycle after the FSM is idle again.
    always_comb begin
        awready_d = (w_state_q == W_IDLE)
                  & (w_state_d == W_IDLE) & ~aw_held_d;
        wready_d  = (w_state_q == W_IDLE)
                  & (w_state_d == W_IDLE) & ~w_held_d;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = resp_of(wr_oor);
        end else if (w_state_q == W_RESP && bus.bready) begin
            bvalid_d = 1'b0;
        end
    end

    // ---------------- read channel ----------------
    r_state_t r_state_q, r_state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ridx_q, ridx_d;
    logic roor_q, roor_d;
    logic arready_q, arready_d;
    logic rvalid_q, rvalid_d;
    logic [1:0] rresp_q, rresp_d;
    logic rzero_q, rzero_d;

    logic ar_hs, ar_oor, rd_en, rd_oor;
    logic [IDX_W-1:0] ar_idx, rd_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign ar_hs  = bus.arvalid & arready_q;
    assign ar_idx = bus.araddr[ADDR_LSB +: IDX_W];
    assign ar_oor = (bus.araddr >> TOP_SH) != '0;
    assign rd_idx = (r_state_q == R_IDLE) ? ar_idx : ridx_q;
    assign rd_oor = (r_state_q == R_IDLE) ? ar_oor : roor_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            cnt_q     <= '0;
            ridx_q    <= '0;
            roor_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rzero_q   <= 1'b1;
        end else begin
            r_state_q <= r_state_d;
            cnt_q     <= cnt_d;
            ridx_q    <= ridx_d;
            roor_q    <= roor_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rzero_q   <= rzero_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        cnt_d     = cnt_q;
        ridx_d    = ridx_q;
        roor_d    = roor_q;
        rd_en     = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ridx_d = ar_idx;
                    roor_d = ar_oor;
                    if (READ_WAIT > 0) begin
                        r_state_d = R_WAIT;
                        cnt_d     = RW_CNT;
                    end else begin
                        r_state_d = R_DATA;
                        rd_en     = 1'b1;
                    end
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    r_state_d = R_DATA;
                    rd_en     = 1'b1;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d = (r_state_q == R_IDLE) & (r_state_d == R_IDLE);
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rzero_d   = rzero_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rresp_d  = resp_of(rd_oor);
            rzero_d  = rd_oor;
        end else if (r_state_q == R_DATA && bus.rready) begin
            rvalid_d = 1'b0;
        end
    end

    axi4_lite_mem_ws_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (commit & ~wr_oor),
        .widx  (wr_addr[ADDR_LSB +: IDX_W]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .re    (rd_en & ~rd_oor),
        .ridx  (rd_idx),
        .rdata (ram_rdata)
    );

    logic prot_unused;
    assign prot_unused = ^{bus.awprot, bus.arprot};

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    // rzero_q masks RAM output after reset and on SLVERR reads.
    assign bus.rdata   = rzero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_axi4_lite_mem_ws.sv
// Scoreboard bench for axi4_lite_mem_ws: one instance with
// READ_WAIT=0 and one with READ_WAIT=3, selected by sel.
module tb_axi4_lite_mem_ws;
    import axi4_lite_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_mem_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m0 ();
    axi4_lite_mem_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m3 ();

    axi4_lite_mem_ws #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .READ_WAIT(0)
    ) u0 (.clk(clk), .rst(rst), .bus(m0.slave));

    axi4_lite_mem_ws #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .READ_WAIT(3)
    ) u3 (.clk(clk), .rst(rst), .bus(m3.slave));

    logic        sel;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;

    assign m0.awaddr  = awaddr;
    assign m0.awprot  = 3'b000;
    assign m0.awvalid = awvalid & ~sel;
    assign m0.wdata   = wdata;
    assign m0.wstrb   = wstrb;
    assign m0.wvalid  = wvalid & ~sel;
    assign m0.bready  = sel ? 1'b1 : bready;
    assign m0.araddr  = araddr;
    assign m0.arprot  = 3'b000;
    assign m0.arvalid = arvalid & ~sel;
    assign m0.rready  = sel ? 1'b1 : rready;

    assign m3.awaddr  = awaddr;
    assign m3.awprot  = 3'b000;
    assign m3.awvalid = awvalid & sel;
    assign m3.wdata   = wdata;
    assign m3.wstrb   = wstrb;
    assign m3.wvalid  = wvalid & sel;
    assign m3.bready  = sel ? bready : 1'b1;
    assign m3.araddr  = araddr;
    assign m3.arprot  = 3'b000;
    assign m3.arvalid = arvalid & sel;
    assign m3.rready  = sel ? rready : 1'b1;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    assign awready = sel ? m3.awready : m0.awready;
    assign wready  = sel ? m3.wready  : m0.wready;
    assign bvalid  = sel ? m3.bvalid  : m0.bvalid;
    assign bresp   = sel ? m3.bresp   : m0.bresp;
    assign arready = sel ? m3.arready : m0.arready;
    assign rvalid  = sel ? m3.rvalid  : m0.rvalid;
    assign rresp   = sel ? m3.rresp   : m0.rresp;
    assign rdata   = sel ? m3.rdata   : m0.rdata;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic [1:0] bq[$];
    rexp_t      rq[$];
    rexp_t      r_e;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the expected response on every handshake.
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
            else check("bresp", 32'(bresp), 32'(bq.pop_front()));
        end
        if (!rst && rvalid && rready) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 32'd1, 32'd0);
            end else begin
                r_e = rq.pop_front();
                check("rdata", rdata, r_e.d);
                check("rresp", 32'(rresp), 32'(r_e.r));
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input int dly);
        bit done = 0;
        int n = 0;
        repeat (dly) @(posedge clk);
        #1;
        awaddr = a;
        awvalid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            if (awready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check("aw_timeout", 32'd1, 32'd0);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                          input int dly);
        bit done = 0;
        int n = 0;
        repeat (dly) @(posedge clk);
        #1;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            if (wready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check("w_timeout", 32'd1, 32'd0);
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit done = 0;
        int n = 0;
        araddr = a;
        arvalid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            if (arready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check("ar_timeout", 32'd1, 32'd0);
        arvalid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] exp,
                      input int wd, input int ad);
        int n = 0;
        bq.push_back(exp);
        fork
            send_aw(a, ad);
            send_w(d, s, wd);
        join
        do begin
            @(negedge clk);
            n++;
        end while (!(bvalid && bready) && n < 50);
        if (n >= 50) check("b_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] r, input int lat);
        int n = 0;
        rq.push_back({d, r});
        send_ar(a);
        do begin
            @(negedge clk);
            n++;
        end while (!rvalid && n < 50);
        check("r_latency", 32'(n), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0;
        awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_awready", 32'(awready), 32'd1);
        check("idle_wready", 32'(wready), 32'd1);
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_arready3", 32'(m3.arready), 32'd1);
        check("idle_bvalid", 32'(bvalid), 32'd0);
        check("idle_rvalid", 32'(rvalid), 32'd0);

        // basic write / read
        wr(32'h4, 32'h5555_5555, 4'hF, RESP_OKAY, 0, 0);
        rd(32'h4, 32'h5555_5555, RESP_OKAY, 1);

        // W two cycles ahead of AW, lanes 0 and 2 only
        wr(32'h4, 32'hAAAA_AAAA, 4'b0101, RESP_OKAY, 0, 2);
        rd(32'h4, 32'h55AA_55AA, RESP_OKAY, 1);

        // zero strobe writes nothing
        wr(32'h4, 32'h0000_0000, 4'b0000, RESP_OKAY, 0, 0);
        rd(32'h4, 32'h55AA_55AA, RESP_OKAY, 1);

        // write back-pressure
        bready = 1'b0;
        bq.push_back(RESP_OKAY);
        fork
            send_aw(32'h8, 0);
            send_w(32'h1357_9BDF, 4'hF, 0);
        join
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid", 32'(bvalid), 32'd1);
            check("bp_bresp", 32'(bresp), 32'(RESP_OKAY));
            check("bp_awready", 32'(awready), 32'd0);
            check("bp_wready", 32'(wready), 32'd0);
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_bvalid_drop", 32'(bvalid), 32'd0);
        @(posedge clk);
        #1;
        check("bp_awready_back", 32'(awready), 32'd1);

        // read back-pressure
        rready = 1'b0;
        rq.push_back({32'h1357_9BDF, RESP_OKAY});
        send_ar(32'h8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rvalid", 32'(rvalid), 32'd1);
            check("bp_rdata", rdata, 32'h1357_9BDF);
            check("bp_rresp", 32'(rresp), 32'(RESP_OKAY));
            check("bp_arready", 32'(arready), 32'd0);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_rvalid_drop", 32'(rvalid), 32'd0);
        check("bp_rdata_hold", rdata, 32'h1357_9BDF);

        // range boundaries; 0x400 would alias word 0
        wr(32'h0, 32'h1234_5678, 4'hF, RESP_OKAY, 0, 0);
        wr(32'h3FC, 32'h0BAD_F00D, 4'hF, RESP_OKAY, 0, 0);
        wr(32'h400, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 0, 0);
        rd(32'h0, 32'h1234_5678, RESP_OKAY, 1);
        rd(32'h3FC, 32'h0BAD_F00D, RESP_OKAY, 1);
        rd(32'h400, 32'h0000_0000, RESP_SLVERR, 1);

        // READ_WAIT=3 instance
        sel = 1'b1;
        wr(32'h10, 32'hCAFE_F00D, 4'hF, RESP_OKAY, 0, 0);
        rd(32'h10, 32'hCAFE_F00D, RESP_OKAY, 4);

        // reset while in R_WAIT
        send_ar(32'h10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        check("mid_rst_awready", 32'(awready), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_rvalid", 32'(rvalid), 32'd0);
        rd(32'h10, 32'hCAFE_F00D, RESP_OKAY, 4);

        sel = 1'b0;
        rd(32'h4, 32'h55AA_55AA, RESP_OKAY, 1);

        repeat (3) @(posedge clk);
        check("bq_empty", 32'(bq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
